// File: rtl/note_player.sv
// Responder side of the song-reader handshake: times one note in beats,
// generates its square-wave tone and pulses note_done when it expires.
module note_player #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int HP_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              load_new_note,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    input  logic              beat,
    input  logic [HP_W-1:0]   half_period,
    output logic [NOTE_W-1:0] rom_addr,
    output logic              note_done,
    output logic              sound_out,
    output logic              busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [NOTE_W-1:0] rom_addr_q, rom_addr_d;
    logic [DUR_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [HP_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic              tone_q, tone_d;
    logic              settle_q, settle_d;
    logic              note_done_q, note_done_d;
    logic              toneRun;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            beat_cnt_q  <= '0;
            tone_cnt_q  <= '0;
            tone_q      <= 1'b0;
            settle_q    <= 1'b0;
            note_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            tone_cnt_q  <= tone_cnt_d;
            tone_q      <= tone_d;
            settle_q    <= settle_d;
            note_done_q <= note_done_d;
        end
    end

    // settle masks the cycle in which the ROM still shows the previous note's data
    assign toneRun = (state_q == PLAYING) && play && !settle_q &&
                     (rom_addr_q != '0) && (half_period != '0);

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        beat_cnt_d  = beat_cnt_q;
        tone_cnt_d  = tone_cnt_q;
        tone_d      = tone_q;
        settle_d    = 1'b0;
        note_done_d = 1'b0;

        if (load_new_note) begin
            rom_addr_d = note;
            beat_cnt_d = duration;
            tone_cnt_d = '0;
            tone_d     = 1'b0;
            settle_d   = 1'b1;
            state_d    = PLAYING;
        end else if (state_q == PLAYING) begin
            // >= rather than == so a half-period that shrinks mid-tone still wraps
            if (toneRun) begin
                if (tone_cnt_q >= half_period - HP_W'(1)) begin
                    tone_cnt_d = '0;
                    tone_d     = ~tone_q;
                end else begin
                    tone_cnt_d = tone_cnt_q + HP_W'(1);
                end
            end
            if (play) begin
                if (beat_cnt_q == '0) begin
                    note_done_d = 1'b1;
                    state_d     = IDLE;
                end else if (beat) begin
                    if (beat_cnt_q == DUR_W'(1)) begin
                        note_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - DUR_W'(1);
                    end
                end
            end
        end else begin
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign note_done = note_done_q;
    assign busy      = (state_q == PLAYING);
    assign sound_out = tone_q & play & (state_q == PLAYING) & (rom_addr_q != '0);

endmodule
